// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, port ids and round-robin pointer encoding for the write arbiter
package regfile_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef enum logic {
    PREF_A = 1'b0,
    PREF_B = 1'b1
  } rr_ptr_e;

  function automatic rr_ptr_e rr_flip(rr_ptr_e p);
    return (p == PREF_A) ? PREF_B : PREF_A;
  endfunction

endpackage

// File: rtl/rf_wr_slot.sv
// rtl/rf_wr_slot.sv - one-entry writeback holding register (valid/dest/data) with capture and release
module rf_wr_slot #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_i,
  input  logic              release_i,
  input  logic [ADDR_W-1:0] dest_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic [ADDR_W-1:0] dest_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q;
  logic [ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0] data_q;

  // capture only happens while empty and release only while full, so they never collide
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else if (capture_i) begin
      full_q <= 1'b1;
      dest_q <= dest_i;
      data_q <= data_i;
    end else if (release_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign dest_o = dest_q;
  assign data_o = data_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - arbitrates ALU (A) and load (B) writebacks onto the single register-file write port
// Optional: ZERO_REG_DISCARD_EN drops dest==0 requests at capture so R0 behaves hardwired.
import regfile_pkg::*;

module regfile_write_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
  input  logic              rf_hold,
  output logic [ADDR_W-1:0] rf_dest,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_load_enable,
  output logic              pending
);

  logic              a_full, b_full;
  logic [ADDR_W-1:0] a_dest_s, b_dest_s;
  logic [DATA_W-1:0] a_data_s, b_data_s;
  logic              a_keep, b_keep, a_cap, b_cap, a_rel, b_rel;
  logic              gnt_vld;
  port_e             gnt_port;
  rr_ptr_e           rr_q, rr_d;
  logic              a_older_q, a_older_d;
  logic [ADDR_W-1:0] rf_dest_q;
  logic [DATA_W-1:0] rf_data_q;
  logic              rf_load_enable_q;

  assign a_ready = ~a_full;
  assign b_ready = ~b_full;
  assign pending = a_full | b_full;

`ifdef ZERO_REG_DISCARD_EN
  assign a_keep = (a_dest != '0);
  assign b_keep = (b_dest != '0);
`else
  assign a_keep = 1'b1;
  assign b_keep = 1'b1;
`endif

  assign a_cap = a_valid & a_ready & a_keep;
  assign b_cap = b_valid & b_ready & b_keep;
  assign a_rel = gnt_vld & (gnt_port == PORT_A);
  assign b_rel = gnt_vld & (gnt_port == PORT_B);

  rf_wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_a (
    .clk(clk), .reset_n(reset_n), .capture_i(a_cap), .release_i(a_rel),
    .dest_i(a_dest), .data_i(a_data), .full_o(a_full), .dest_o(a_dest_s), .data_o(a_data_s)
  );

  rf_wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_b (
    .clk(clk), .reset_n(reset_n), .capture_i(b_cap), .release_i(b_rel),
    .dest_i(b_dest), .data_i(b_data), .full_o(b_full), .dest_o(b_dest_s), .data_o(b_data_s)
  );

  // a slot only captures while empty, so the newcomer is always younger than any resident entry
  always_comb begin
    a_older_d = a_older_q;
    if (a_cap && b_cap)  a_older_d = 1'b1;
    else if (a_cap)      a_older_d = 1'b0;
    else if (b_cap)      a_older_d = 1'b1;
  end

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = PORT_A;
    rr_d     = rr_q;
    if (!rf_hold) begin
      if (a_full && b_full) begin
        gnt_vld = 1'b1;
        if (a_dest_s != b_dest_s) begin
          gnt_port = (rr_q == PREF_A) ? PORT_A : PORT_B;
          rr_d     = rr_flip(rr_q);
        end else begin
          // same register: program order decides, round-robin is left alone
          gnt_port = a_older_q ? PORT_A : PORT_B;
        end
      end else if (a_full) begin
        gnt_vld  = 1'b1;
        gnt_port = PORT_A;
      end else if (b_full) begin
        gnt_vld  = 1'b1;
        gnt_port = PORT_B;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q             <= PREF_A;
      a_older_q        <= 1'b0;
      rf_load_enable_q <= 1'b0;
      rf_dest_q        <= '0;
      rf_data_q        <= '0;
    end else begin
      rr_q             <= rr_d;
      a_older_q        <= a_older_d;
      rf_load_enable_q <= gnt_vld;
      if (gnt_vld) begin
        rf_dest_q <= (gnt_port == PORT_A) ? a_dest_s : b_dest_s;
        rf_data_q <= (gnt_port == PORT_A) ? a_data_s : b_data_s;
      end
    end
  end

  assign rf_dest        = rf_dest_q;
  assign rf_data        = rf_data_q;
  assign rf_load_enable = rf_load_enable_q;

endmodule
